// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider)
// Define MD_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_seq_unit #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   op,
   input  logic [n-1:0] rs1,
   input  logic [n-1:0] rs2,
   input  logic         flush,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [n-1:0] result,
   output logic         busy
);
   localparam int CW = $clog2(n);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
   localparam logic [n-1:0]  MIN_NEG  = {1'b1, {(n-1){1'b0}}};

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*n-1:0] acc_q, acc_d;
   logic [n-1:0]   opb_q, opb_d;
   logic [2:0]     op_q, op_d;
   logic           sa_q, sa_d, sb_q, sb_d;
   logic           spec_q, spec_d;
   logic [n-1:0]   spec_res_q, spec_res_d;
   logic [n-1:0]   result_q, result_d;

   logic           in_sa, in_sb;
   logic [n-1:0]   mag_a, mag_b;
   logic           in_spec;
   logic [n-1:0]   in_spec_res;
   logic [n:0]     add_sum, shl, trial;
   logic [2*n-1:0] mul_next, div_next, prod;
   logic [n-1:0]   quo_fix, rem_fix, fix_res;

   assign in_sa = rs1[n-1] & ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110));
   assign in_sb = rs2[n-1] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
   assign mag_a = in_sa ? -rs1 : rs1;
   assign mag_b = in_sb ? -rs2 : rs2;

   // Special results are resolved at accept so FIX (or early-out) only has to select them.
   always_comb begin
      in_spec     = 1'b0;
      in_spec_res = '0;
      if (op[2]) begin
         if (rs2 == '0) begin
            in_spec     = 1'b1;
            in_spec_res = op[1] ? rs1 : '1;
         end else if (!op[0] && rs1 == MIN_NEG && rs2 == '1) begin
            in_spec     = 1'b1;
            in_spec_res = op[1] ? '0 : rs1;
         end
      end
`ifdef MD_EARLY_OUT_EN
      else if (rs1 == '0 || rs2 == '0) begin
         in_spec     = 1'b1;
         in_spec_res = '0;
      end
`endif
   end

   assign add_sum  = {1'b0, acc_q[2*n-1:n]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {add_sum, acc_q[n-1:1]} : {1'b0, acc_q[2*n-1:1]};
   assign shl      = {acc_q[2*n-1:n], acc_q[n-1]};
   assign trial    = shl - {1'b0, opb_q};
   assign div_next = trial[n] ? {shl[n-1:0], acc_q[n-2:0], 1'b0}
                              : {trial[n-1:0], acc_q[n-2:0], 1'b1};

   assign prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo_fix = (sa_q ^ sb_q) ? -acc_q[n-1:0] : acc_q[n-1:0];
   assign rem_fix = sa_q ? -acc_q[2*n-1:n] : acc_q[2*n-1:n];
   assign fix_res = !op_q[2] ? ((op_q[1:0] == 2'b00) ? prod[n-1:0] : prod[2*n-1:n])
                             : (op_q[1] ? rem_fix : quo_fix);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      op_d       = op_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               op_d       = op;
               sa_d       = in_sa;
               sb_d       = in_sb;
               acc_d      = {{n{1'b0}}, mag_a};
               opb_d      = mag_b;
               cnt_d      = CNT_LAST;
               spec_d     = in_spec;
               spec_res_d = in_spec_res;
`ifdef MD_EARLY_OUT_EN
               if (in_spec) begin
                  state_d  = S_DONE;
                  result_d = in_spec_res;
               end else begin
                  state_d  = S_CALC;
               end
`else
               state_d    = S_CALC;
`endif
            end
         end
         S_CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_FIX: begin
            result_d = spec_q ? spec_res_q : fix_res;
            state_d  = S_DONE;
         end
         default: begin
            if (resp_ready) state_d = S_IDLE;
         end
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         op_q       <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         op_q       <= op_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign result     = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb/tb_muldiv_seq_unit.sv - randomized self-checking bench for muldiv_seq_unit against an arithmetic reference
module tb_muldiv_seq_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] result;
   logic        busy;

   int total = 0;
   int bad   = 0;

   muldiv_seq_unit #(.n(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op         (op),
      .rs1        (rs1),
      .rs2        (rs2),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint     sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      res = '0;
      case (f)
         3'd0: begin p = 64'(sa * sb); res = p[31:0];  end
         3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
         3'd2: begin p = 64'(sa * ub); res = p[63:32]; end
         3'd3: begin p = 64'(ua * ub); res = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
            else begin p = 64'(sa / sb); res = p[31:0]; end
         end
         3'd5: res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
            else begin p = 64'(sa % sb); res = p[31:0]; end
         end
         default: res = (b == 32'd0) ? a : a % b;
      endcase
      return res;
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int lat;
      lat = 34;
`ifdef MD_EARLY_OUT_EN
      if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) lat = 1;
      if (!f[2] && (a == 32'd0 || b == 32'd0)) lat = 1;
`endif
      return lat;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
      int          lat;
      logic [31:0] exp;
      exp = ref_md(f, a, b);
      chk({tag, ".req_ready"}, req_ready, 1);
      req_valid = 1'b1; op = f; rs1 = a; rs2 = b;
      @(posedge clk); #1;
      req_valid = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, lat, ref_lat(f, a, b));
      chk({tag, ".result"}, result, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, ".hold"}, {resp_valid, req_ready, result}, {1'b1, 1'b0, exp});
      end
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk({tag, ".after"}, {resp_valid, busy, req_ready}, 3'b001);
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
      flush = 1'b0; resp_ready = 1'b0;
      #1;
      chk("reset", {req_ready, resp_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'd0});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("mul_7_m3",  3'd0, 32'd7,          32'hFFFF_FFFD, 0);
      chk("mul_7_m3.const", ref_md(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      do_op("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 0);
      do_op("mulhsu_min",3'd2, 32'h8000_0000,  32'h8000_0000, 0);
      do_op("mulhu_min", 3'd3, 32'h8000_0000,  32'h8000_0000, 0);
      do_op("div_m7_2",  3'd4, 32'hFFFF_FFF9,  32'd2, 0);
      do_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9,  32'd2, 0);
      do_op("divu_max",  3'd5, 32'hFFFF_FFFF,  32'd2, 0);
      do_op("remu_9_4",  3'd7, 32'd9,          32'd4, 0);
      do_op("div_by0",   3'd4, 32'd5,          32'd0, 0);
      do_op("rem_by0",   3'd6, 32'd5,          32'd0, 0);
      do_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
      do_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
      do_op("backpress", 3'd5, 32'd1000,       32'd7, 10);
      do_op("next_acc",  3'd0, 32'd6,          32'd9, 0);

      // flush at CALC cycle 5, with a competing request that must be ignored
      req_valid = 1'b1; op = 3'd0; rs1 = 32'd11; rs2 = 32'd13;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 flush = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      chk("flush.idle", {resp_valid, busy, req_ready}, 3'b001);
      watch_quiet("flush.no_resp", 40);

      // asynchronous reset in the middle of CALC
      req_valid = 1'b1; op = 3'd4; rs1 = 32'd100; rs2 = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst.idle", {resp_valid, busy, req_ready, result}, {3'b001, 32'd0});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst.ready", {resp_valid, req_ready}, 2'b01);
      watch_quiet("rst.no_resp", 40);
      do_op("mul_3_4", 3'd0, 32'd3, 32'd4, 0);

      for (int k = 0; k < 40; k++) begin
         do_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
